mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Bus-side responder for the single-cycle CPU's data port (m_addr/m_read/m_write/d_t_mem/d_f_mem).
- Decodes each access to one of three targets:
  - word-addressed data RAM
  - keyboard scan-code FIFO
  - LED and timer registers
- Returns read data combinationally in the same cycle, as a single-cycle core requires.
- Commits writes and side effects (FIFO pop, register loads) on the next rising clock edge.

Parameters:
- RAM_WORDS, 1024, data RAM depth in 32-bit words; power of 2.
- KBD_DEPTH, 8, keyboard FIFO depth in bytes; power of 2, at least 2.
- IO_BASE, 32'hA000_0000, base byte address of the I/O register window.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- m_addr  in  32  byte address from CPU; bits [1:0] ignored (word access).
- m_read  in  1  read strobe; qualifies read side effects.
- m_write  in  1  write strobe.
- d_t_mem  in  32  store data from CPU.
- d_f_mem  out  32  load data to CPU, combinational.
- kbd_data  in  8  scan code from keyboard front end.
- kbd_valid  in  1  one-cycle push strobe for kbd_data.
- led  out  16  LED register.
- kbd_irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (rst high at posedge) takes effect next cycle:
  - FIFO empty, overflow = 0, led = 16'h0, timer = 0.
  - kbd_irq = 0.
  - RAM contents not cleared.
- Address map. Word index = m_addr[31:2].
  - RAM: m_addr < RAM_WORDS*4.
  - KBD_DATA (IO_BASE+0x0):
    - Read returns {24'h0, head byte}, or 32'h0 if empty.
    - m_read=1 and non-empty pops at posedge.
    - Write ignored.
  - KBD_STAT (IO_BASE+0x4):
    - Read returns {29'h0, overflow, full, ~empty}.
    - Any write clears overflow.
  - LED (IO_BASE+0x8):
    - Read returns {16'h0, led}.
    - Write loads d_t_mem[15:0].
  - TIMER (IO_BASE+0xC):
    - Read returns current count.
    - Write loads d_t_mem.
  - Any other address: read returns 32'h0; write ignored; no side effects.
- d_f_mem: purely combinational from m_addr and current state, independent of m_read. The CPU selects bytes itself.
- RAM:
  - Asynchronous read.
  - Write at posedge when m_write=1 and address is in range.
- Side effects never occur unless the matching strobe is high.
  - m_addr=0 with m_read=0 must not pop anything.
  - If m_read and m_write are both high, both take effect independently.
- Timer:
  - Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
  - A write wins over increment in that cycle: next value = written value; counting resumes the following cycle.
- FIFO:
  - Push on kbd_valid.
  - Pop as above; data becomes visible the cycle after the push.
  - Pointers wrap modulo KBD_DEPTH; count width is log2(KBD_DEPTH)+1.
  - Push and pop in the same cycle when non-empty: both happen, count unchanged. This includes the full case, so no overflow.
  - Push and pop in the same cycle when empty: push only, since the pop finds nothing.
  - Push when full without a pop: byte dropped, overflow set (sticky).
  - Pop when empty: no change.
  - Overflow clear and a new overflow in the same cycle: set wins.
- kbd_irq = ~empty, registered state, no extra latency.

Decomposition:
- Package mem_io_pkg holds:
  - offset constants KBD_DATA_OFF, KBD_STAT_OFF, LED_OFF, TIMER_OFF;
  - STAT bit indices;
  - a target-select enum {SEL_RAM, SEL_KBD_DATA, SEL_KBD_STAT, SEL_LED, SEL_TIMER, SEL_NONE}.
- Sub-module io_kbd_fifo, parameterised by KBD_DEPTH:
  - inputs: push, pop, din, clr_ovf;
  - outputs: dout, empty, full, overflow.
- The top level holds the decoder, RAM, LED and timer.

Test Plan:
- Reset, then read KBD_STAT -> d_f_mem=0. Read TIMER 3 cycles after reset -> 2 or 3 consistent with counting from 0 after reset; led=0, kbd_irq=0.
- sw 0xDEADBEEF to 0x10, then lw 0x10 and 0x13 -> both return 0xDEADBEEF. Write to RAM_WORDS*4 -> no RAM word changes.
- Push 0x1C, 0x32 -> kbd_irq=1, STAT=0x1.
  - Read KBD_DATA -> 0x1C, then 0x32, then 0x0.
  - STAT=0 after the second pop.
  - With m_read=0 at the same address, the head is not popped.
- Push 9 bytes into an empty depth-8 FIFO -> STAT=0x7, the 9th byte is lost, and the first pop returns byte 1. Write KBD_STAT -> STAT=0x3.
- Full FIFO with push and pop in the same cycle -> no overflow, count stays 8, new byte is last out.
- Write 0xFFFFFFFE to TIMER -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x0 over the next cycles.
- Write 0x1234A5A5 to LED -> led=0xA5A5.
- rst asserted with non-empty FIFO and led set -> all state cleared next cycle.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and types for the CPU data-port responder: I/O register
// offsets, keyboard status bit positions and the address-decode target select.
package mem_io_pkg;

    localparam logic [31:0] KBD_DATA_OFF = 32'h0000_0000;
    localparam logic [31:0] KBD_STAT_OFF = 32'h0000_0004;
    localparam logic [31:0] LED_OFF      = 32'h0000_0008;
    localparam logic [31:0] TIMER_OFF    = 32'h0000_000C;

    localparam int STAT_NEMPTY_BIT = 0;
    localparam int STAT_FULL_BIT   = 1;
    localparam int STAT_OVF_BIT    = 2;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBD_DATA,
        SEL_KBD_STAT,
        SEL_LED,
        SEL_TIMER,
        SEL_NONE
    } sel_t;

    // Word index (byte address >> 2) of a register inside the I/O window.
    function automatic logic [29:0] io_word(input logic [31:0] base, input logic [31:0] off);
        logic [31:0] byte_addr;
        byte_addr = base + off;
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/io_kbd_fifo.sv
// Byte FIFO for keyboard scan codes with a sticky overflow flag.
// A pop on a non-empty FIFO frees a slot, so push-and-pop while full never overflows.
module io_kbd_fifo #(
    parameter int KBD_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    input  logic       clr_ovf,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int AW = $clog2(KBD_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(KBD_DEPTH);

    logic [7:0]    mem_q [KBD_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_CNT);
    assign overflow = ovf_q;
    assign dout     = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
        // A byte dropped this cycle sets the flag even if software clears it now.
        ovf_d = ovf_q;
        if (push && !do_push) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Data-port responder for a single-cycle CPU: decodes each access to RAM,
// keyboard FIFO or LED/timer registers; reads are combinational, writes commit on posedge.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter int          KBD_DEPTH = 8,
    parameter logic [31:0] IO_BASE   = 32'hA000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_addr,
    input  logic        m_read,
    input  logic        m_write,
    input  logic [31:0] d_t_mem,
    output logic [31:0] d_f_mem,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [15:0] led,
    output logic        kbd_irq
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    localparam logic [29:0] KBD_DATA_W = io_word(IO_BASE, KBD_DATA_OFF);
    localparam logic [29:0] KBD_STAT_W = io_word(IO_BASE, KBD_STAT_OFF);
    localparam logic [29:0] LED_W      = io_word(IO_BASE, LED_OFF);
    localparam logic [29:0] TIMER_W    = io_word(IO_BASE, TIMER_OFF);

    sel_t              sel;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram_q [RAM_WORDS];
    logic [15:0]       led_q, led_d;
    logic [31:0]       timer_q, timer_d;
    logic              fifo_pop, fifo_clr;
    logic [7:0]        fifo_dout;
    logic              fifo_empty, fifo_full, fifo_ovf;
    logic              unused_addr_lsbs;

    // Loads and stores are word-wide; the CPU handles byte lanes itself.
    assign unused_addr_lsbs = ^m_addr[1:0];
    assign ram_idx          = m_addr[RAM_AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if ({1'b0, m_addr} < RAM_BYTES) begin
            sel = SEL_RAM;
        end else if (m_addr[31:2] == KBD_DATA_W) begin
            sel = SEL_KBD_DATA;
        end else if (m_addr[31:2] == KBD_STAT_W) begin
            sel = SEL_KBD_STAT;
        end else if (m_addr[31:2] == LED_W) begin
            sel = SEL_LED;
        end else if (m_addr[31:2] == TIMER_W) begin
            sel = SEL_TIMER;
        end
    end

    always_comb begin
        d_f_mem = 32'h0;
        unique case (sel)
            SEL_RAM:      d_f_mem = ram_q[ram_idx];
            SEL_KBD_DATA: d_f_mem = {24'h0, fifo_empty ? 8'h00 : fifo_dout};
            SEL_KBD_STAT: begin
                d_f_mem[STAT_NEMPTY_BIT] = !fifo_empty;
                d_f_mem[STAT_FULL_BIT]   = fifo_full;
                d_f_mem[STAT_OVF_BIT]    = fifo_ovf;
            end
            SEL_LED:      d_f_mem = {16'h0, led_q};
            SEL_TIMER:    d_f_mem = timer_q;
            default:      d_f_mem = 32'h0;
        endcase
    end

    always_comb begin
        fifo_pop = m_read && (sel == SEL_KBD_DATA);
        fifo_clr = m_write && (sel == SEL_KBD_STAT);
        led_d    = (m_write && sel == SEL_LED) ? d_t_mem[15:0] : led_q;
        // A store to the timer overrides this cycle's increment.
        timer_d  = (m_write && sel == SEL_TIMER) ? d_t_mem : timer_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= 16'h0;
            timer_q <= 32'h0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk) begin
        if (m_write && sel == SEL_RAM) begin
            ram_q[ram_idx] <= d_t_mem;
        end
    end

    io_kbd_fifo #(
        .KBD_DEPTH (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (kbd_valid),
        .pop      (fifo_pop),
        .din      (kbd_data),
        .clr_ovf  (fifo_clr),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_ovf)
    );

    assign led     = led_q;
    assign kbd_irq = !fifo_empty;

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomised and directed check of mem_io_responder against a queue/array model.
module tb_mem_io_responder;

    localparam int          RAM_WORDS = 1024;
    localparam int          KBD_DEPTH = 8;
    localparam logic [31:0] IO        = 32'hA000_0000;
    localparam logic [31:0] A_DATA    = IO + 32'h0;
    localparam logic [31:0] A_STAT    = IO + 32'h4;
    localparam logic [31:0] A_LED     = IO + 32'h8;
    localparam logic [31:0] A_TIMER   = IO + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_addr;
    logic        m_read;
    logic        m_write;
    logic [31:0] d_t_mem;
    logic [31:0] d_f_mem;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic [15:0] led;
    logic        kbd_irq;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0]  q_m[$];
    bit          ovf_m;
    logic [15:0] led_m;
    logic [31:0] timer_m;
    logic [31:0] ram_m [RAM_WORDS];
    bit          ram_v [RAM_WORDS];
    logic [31:0] rd_obs;

    always #5 clk = ~clk;

    mem_io_responder #(
        .RAM_WORDS (RAM_WORDS),
        .KBD_DEPTH (KBD_DEPTH),
        .IO_BASE   (IO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_addr    (m_addr),
        .m_read    (m_read),
        .m_write   (m_write),
        .d_t_mem   (d_t_mem),
        .d_f_mem   (d_f_mem),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .led       (led),
        .kbd_irq   (kbd_irq)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
        known = 1'b1;
        if (a < RAM_WORDS * 4) begin
            known = ram_v[a[11:2]];
            return ram_m[a[11:2]];
        end
        case ({a[31:2], 2'b00})
            A_DATA:  return (q_m.size() != 0) ? {24'h0, q_m[0]} : 32'h0;
            A_STAT:  return {29'h0, ovf_m, q_m.size() == KBD_DEPTH, q_m.size() != 0};
            A_LED:   return {16'h0, led_m};
            A_TIMER: return timer_m;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update(input bit r, input logic [31:0] a, input bit rd, input bit wr,
                                input logic [31:0] wd, input bit kv, input logic [7:0] kd);
        logic [31:0] wa;
        bit          popped;
        bit          was_full;
        bit          set_ovf;
        wa = {a[31:2], 2'b00};
        if (r) begin
            q_m.delete();
            ovf_m   = 1'b0;
            led_m   = 16'h0;
            timer_m = 32'h0;
        end else begin
            was_full = (q_m.size() == KBD_DEPTH);
            popped   = 1'b0;
            set_ovf  = 1'b0;
            if (rd && wa == A_DATA && q_m.size() != 0) begin
                void'(q_m.pop_front());
                popped = 1'b1;
            end
            if (kv) begin
                if (was_full && !popped) set_ovf = 1'b1;
                else q_m.push_back(kd);
            end
            if (set_ovf) ovf_m = 1'b1;
            else if (wr && wa == A_STAT) ovf_m = 1'b0;
            if (wr && wa == A_LED) led_m = wd[15:0];
            timer_m = (wr && wa == A_TIMER) ? wd : timer_m + 32'd1;
        end
        if (wr && a < RAM_WORDS * 4) begin
            ram_m[a[11:2]] = wd;
            ram_v[a[11:2]] = 1'b1;
        end
    endtask

    // One bus cycle: drive at negedge, sample mid-low phase, model advances at posedge.
    task automatic step(input bit r, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input bit kv, input logic [7:0] kd);
        logic [31:0] exp;
        bit          known;
        @(negedge clk);
        rst = r; m_addr = a; m_read = rd; m_write = wr; d_t_mem = wd;
        kbd_valid = kv; kbd_data = kd;
        #2;
        rd_obs = d_f_mem;
        exp = model_read(a, known);
        if (known) check_val($sformatf("rd@%h", a), d_f_mem, exp);
        check_val("led", {16'h0, led}, {16'h0, led_m});
        check_val("irq", {31'h0, kbd_irq}, {31'h0, q_m.size() != 0});
        @(posedge clk);
        model_update(r, a, rd, wr, wd, kv, kd);
    endtask

    task automatic idle(input logic [31:0] a, input bit rd);
        step(1'b0, a, rd, 1'b0, 32'h0, 1'b0, 8'h0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        step(1'b0, 32'h4000_0000, 1'b0, 1'b0, 32'h0, 1'b1, b);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        rst = 1'b1; m_addr = '0; m_read = 1'b0; m_write = 1'b0; d_t_mem = '0;
        kbd_valid = 1'b0; kbd_data = '0;
        q_m.delete(); ovf_m = 1'b0; led_m = '0; timer_m = '0;
        for (int i = 0; i < RAM_WORDS; i++) ram_v[i] = 1'b0;

        // Reset and post-reset state
        step(1'b1, A_STAT, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
        idle(A_STAT, 1'b1);
        check_val("stat_rst", rd_obs, 32'h0);
        idle(32'h0, 1'b0);
        idle(A_TIMER, 1'b1);
        check_val("timer_rst", rd_obs, 32'd2);

        // RAM store/load, unaligned load, out-of-range store
        for (int i = 0; i < 16; i++) step(1'b0, 32'(i * 4), 1'b0, 1'b1, $urandom, 1'b0, 8'h0);
        step(1'b0, 32'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h0);
        idle(32'h10, 1'b1);
        check_val("lw10", rd_obs, 32'hDEAD_BEEF);
        idle(32'h13, 1'b1);
        check_val("lw13", rd_obs, 32'hDEAD_BEEF);
        step(1'b0, 32'hFFC, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 8'h0);
        step(1'b0, RAM_WORDS * 4, 1'b0, 1'b1, 32'h1111_2222, 1'b0, 8'h0);
        idle(32'h0, 1'b1);
        idle(32'hFFC, 1'b1);
        check_val("ram_last", rd_obs, 32'h0BAD_F00D);
        idle(RAM_WORDS * 4, 1'b1);
        check_val("ram_oob", rd_obs, 32'h0);

        // Two pushes, non-popping look, then pops
        push_byte(8'h1C);
        push_byte(8'h32);
        idle(A_STAT, 1'b1);
        check_val("stat_2", rd_obs, 32'h1);
        idle(A_DATA, 1'b0);
        idle(A_DATA, 1'b0);
        check_val("peek", rd_obs, 32'h1C);
        idle(A_DATA, 1'b1);
        check_val("pop1", rd_obs, 32'h1C);
        idle(A_DATA, 1'b1);
        check_val("pop2", rd_obs, 32'h32);
        idle(A_DATA, 1'b1);
        check_val("pop_empty", rd_obs, 32'h0);
        idle(A_STAT, 1'b1);
        check_val("stat_0", rd_obs, 32'h0);

        // Overflow: nine pushes into depth eight
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        idle(A_STAT, 1'b1);
        check_val("stat_ovf", rd_obs, 32'h7);
        step(1'b0, A_STAT, 1'b0, 1'b1, 32'h0, 1'b0, 8'h0);
        idle(A_STAT, 1'b1);
        check_val("stat_clr", rd_obs, 32'h3);
        // Full FIFO: push and pop in the same cycle
        step(1'b0, A_DATA, 1'b1, 1'b0, 32'h0, 1'b1, 8'h77);
        check_val("pop_full", rd_obs, 32'h1);
        idle(A_STAT, 1'b1);
        check_val("stat_full", rd_obs, 32'h3);
        for (int i = 0; i < 8; i++) idle(A_DATA, 1'b1);
        check_val("last_out", rd_obs, 32'h77);

        // Timer wrap and LED load
        step(1'b0, A_TIMER, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 8'h0);
        idle(A_TIMER, 1'b1);
        check_val("tmr0", rd_obs, 32'hFFFF_FFFE);
        idle(A_TIMER, 1'b1);
        check_val("tmr1", rd_obs, 32'hFFFF_FFFF);
        idle(A_TIMER, 1'b1);
        check_val("tmr2", rd_obs, 32'h0);
        step(1'b0, A_LED, 1'b0, 1'b1, 32'h1234_A5A5, 1'b0, 8'h0);
        idle(A_LED, 1'b1);
        check_val("led_reg", {16'h0, led}, 32'hA5A5);

        // Reset with live state
        push_byte(8'h55);
        step(1'b1, A_STAT, 1'b0, 1'b0, 32'h0, 1'b0, 8'h0);
        idle(A_STAT, 1'b1);
        check_val("rst_stat", rd_obs, 32'h0);
        check_val("rst_led", {16'h0, led}, 32'h0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 7);
            case (k)
                0, 1: a = {20'h0, 6'h0, 4'($urandom), 2'($urandom)};
                2, 3: a = A_DATA;
                4:    a = A_STAT;
                5:    a = A_LED;
                6:    a = ($urandom_range(0, 9) == 0) ? A_TIMER : IO + 32'h10;
                default: a = 32'h5000_0000 | 32'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 99) == 0, a, 1'($urandom), $urandom_range(0, 2) == 0,
                 $urandom, $urandom_range(0, 9) < 4, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
